conexion_p1_a_p2: RTL and testbench
===================================

Name: conexion_p1_a_p2

Overview:
- Return path of the P2→P1 link: takes the 5-bit data field and two 1-bit flags latched on the P1 side and delivers them back to P2.
- Delivery is three sequential field transfers over a valid/ack handshake.
- A per-field watchdog aborts a stalled transfer.
- Sits between the P1 output registers (5-bit value, two flags) and the P2 control FSM.

Parameters:
- ANCHO_DATO, 5, width of the data field.
- TIMEOUT, 255, max cycles a field waits for ack before abort (≥1).
- ANCHO_CNT, 8, watchdog counter width; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- listo  input  1  one-cycle strobe: P1 fields are stable, start a transfer.
- qq_in  input  ANCHO_DATO  data field from P1.
- q_in  input  1  first flag from P1.
- q1_in  input  1  second flag from P1.
- ack  input  1  P2 accepts the current field.
- dato_out  output  ANCHO_DATO  field being presented; flags are zero-extended in bit 0.
- sel  output  2  field select: 00 data, 01 flag q, 10 flag q1, 11 unused.
- valido  output  1  dato_out/sel are valid.
- ocupado  output  1  transfer in progress.
- hecho  output  1  one-cycle pulse when all three fields have been acknowledged.
- error_to  output  1  one-cycle pulse on watchdog abort.
- perdido  output  1  sticky: a listo arrived while ocupado=1; cleared only by reset or by the next accepted listo.

Behaviour:
- Reset (async, immediate): state=IDLE, dato_out=0, sel=00, valido=0, ocupado=0, hecho=0, error_to=0, perdido=0, watchdog=0, snapshot registers=0.
- All outputs are registered.
- States: IDLE, ENV_D, ENV_Q, ENV_Q1, FIN, ERR.
- IDLE:
  - listo=1 → snapshot qq_in/q_in/q_in1 in the same edge, clear perdido, go ENV_D.
  - The next cycle shows valido=1, sel=00, ocupado=1. Latency from listo to valido is 1 cycle.
- ENV_x:
  - valido=1; dato_out and sel hold the snapshot field.
  - A rising edge with ack=1 advances to the next field: ENV_D→ENV_Q→ENV_Q1→FIN. The new field appears in the next cycle with valido still 1, so back-to-back acks give 1 field per cycle.
  - The watchdog resets to 0 on every field entry and increments each cycle without ack.
  - When watchdog==TIMEOUT-1 and ack=0 → go ERR.
  - ack on the same edge that the watchdog would expire: ack wins, advance.
- FIN: valido=0, hecho=1 for exactly one cycle, ocupado=0 in that cycle, then IDLE.
- ERR: valido=0, error_to=1 for exactly one cycle, ocupado=0, then IDLE. Snapshot is retained but unused.
- ack while valido=0: ignored.
- listo while ocupado=1 (any ENV state):
  - Ignored for data; the snapshot does not change.
  - perdido←1.
- listo in FIN/ERR: treated as "busy" (perdido←1, no start). Listo is accepted only in IDLE.
- Inputs changing mid-transfer have no effect; only the snapshot is sent.
- Reset asserted mid-transfer aborts immediately with no hecho/error_to pulse.
- dato_out for flags is {ANCHO_DATO-1 zeros, flag}. sel=11 is never driven.

Decomposition:
- Shared package: state encoding constants (IDLE..ERR) and the sel codes SEL_DATO=00, SEL_Q=01, SEL_Q1=10.
- One natural sub-module: watchdog_cnt. It is a loadable up-counter with clear/enable and a terminal-count output at TIMEOUT-1.
- The FSM, snapshot registers and output mux stay in the top.

Test Plan:
- Nominal transfer:
  - Stimulus: listo with qq_in=5'b10110, q_in=1, q1_in=0; ack tied high.
  - Response: valido rises 1 cycle after listo; cycles show (sel=00, dato=10110), (01, 00001), (10, 00000); hecho pulses the cycle after the third ack; ocupado low again.
- Slow consumer:
  - Stimulus: ack pulsed every 4th cycle.
  - Response: each field is held stable until its ack; no error_to; hecho after the third ack.
- Timeout:
  - Stimulus: TIMEOUT=8, listo, ack never asserted.
  - Response: valido high for exactly 8 cycles with sel=00; error_to pulses once; returns to IDLE; hecho never asserted.
- Overrun and snapshot:
  - Stimulus: listo during ENV_Q with qq_in changed to 5'b00011.
  - Response: perdido=1; remaining fields come from the original snapshot. The next listo in IDLE clears perdido and sends 00011.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously in ENV_Q1.
  - Response: all outputs 0 immediately (before the next edge); no hecho/error_to. After release, a new listo gives a full normal transfer.
- Ack/timeout race:
  - Stimulus: TIMEOUT=4, ack on the 4th waiting cycle of ENV_D.
  - Response: advance to ENV_Q, no error_to.

Source files
------------

// File: rtl/conexion_p1_a_p2_pkg.sv
// Shared definitions for the P1->P2 return path: FSM state encoding and field-select codes.
package conexion_p1_a_p2_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ENV_D  = 3'd1,
      ENV_Q  = 3'd2,
      ENV_Q1 = 3'd3,
      FIN    = 3'd4,
      ERR    = 3'd5
   } estado_t;

   localparam logic [1:0] SEL_DATO = 2'b00;
   localparam logic [1:0] SEL_Q    = 2'b01;
   localparam logic [1:0] SEL_Q1   = 2'b10;

   // True while a field is presented and waiting for ack
   function automatic logic en_envio(input estado_t e);
      return (e == ENV_D) || (e == ENV_Q) || (e == ENV_Q1);
   endfunction

endpackage

// File: rtl/conexion_p1_a_p2_watchdog_cnt.sv
// Per-field watchdog: loadable up-counter with clear/enable and terminal count at TIMEOUT-1.
module conexion_p1_a_p2_watchdog_cnt #(
   parameter int unsigned ANCHO_CNT = 8,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 load,
   input  logic [ANCHO_CNT-1:0] valor,
   output logic                 tc_c
);

   logic [ANCHO_CNT-1:0] cnt;

   // Clear has priority so an ack on the expiry cycle restarts the count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= valor;
      end else if (en) begin
         cnt <= cnt + ANCHO_CNT'(1);
      end
   end

   assign tc_c = (cnt == ANCHO_CNT'(TIMEOUT - 1));

endmodule

// File: rtl/conexion_p1_a_p2.sv
// Returns the P1 data field and two flags to P2 as three valid/ack field transfers with a watchdog.
module conexion_p1_a_p2
   import conexion_p1_a_p2_pkg::*;
#(
   parameter int unsigned ANCHO_DATO = 5,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned ANCHO_CNT  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  listo,
   input  logic [ANCHO_DATO-1:0] qq_in,
   input  logic                  q_in,
   input  logic                  q1_in,
   input  logic                  ack,
   output logic [ANCHO_DATO-1:0] dato_out,
   output logic [1:0]            sel,
   output logic                  valido,
   output logic                  ocupado,
   output logic                  hecho,
   output logic                  error_to,
   output logic                  perdido
);

   estado_t estado;
   logic    snap_q;
   logic    snap_q1;
   logic    wd_en_c;
   logic    wd_clr_c;
   logic    wd_tc_c;

   assign wd_en_c  = en_envio(estado);
   assign wd_clr_c = !wd_en_c || ack;

   conexion_p1_a_p2_watchdog_cnt #(
      .ANCHO_CNT (ANCHO_CNT),
      .TIMEOUT   (TIMEOUT)
   ) u_watchdog (
      .clk   (clk),
      .reset (reset),
      .clr   (wd_clr_c),
      .en    (wd_en_c),
      .load  (1'b0),
      .valor ('0),
      .tc_c  (wd_tc_c)
   );

   // dato_out doubles as the data-field snapshot; the flags are held separately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado   <= IDLE;
         dato_out <= '0;
         sel      <= SEL_DATO;
         valido   <= 1'b0;
         ocupado  <= 1'b0;
         hecho    <= 1'b0;
         error_to <= 1'b0;
         perdido  <= 1'b0;
         snap_q   <= 1'b0;
         snap_q1  <= 1'b0;
      end else begin
         hecho    <= 1'b0;
         error_to <= 1'b0;
         if (listo && (estado != IDLE)) begin
            perdido <= 1'b1;
         end
         unique case (estado)
            IDLE: begin
               if (listo) begin
                  estado   <= ENV_D;
                  snap_q   <= q_in;
                  snap_q1  <= q1_in;
                  dato_out <= qq_in;
                  sel      <= SEL_DATO;
                  valido   <= 1'b1;
                  ocupado  <= 1'b1;
                  perdido  <= 1'b0;
               end
            end
            ENV_D, ENV_Q, ENV_Q1: begin
               if (ack) begin
                  if (estado == ENV_D) begin
                     estado   <= ENV_Q;
                     sel      <= SEL_Q;
                     dato_out <= ANCHO_DATO'(snap_q);
                  end else if (estado == ENV_Q) begin
                     estado   <= ENV_Q1;
                     sel      <= SEL_Q1;
                     dato_out <= ANCHO_DATO'(snap_q1);
                  end else begin
                     estado   <= FIN;
                     sel      <= SEL_DATO;
                     dato_out <= '0;
                     valido   <= 1'b0;
                     ocupado  <= 1'b0;
                     hecho    <= 1'b1;
                  end
               end else if (wd_tc_c) begin
                  estado   <= ERR;
                  sel      <= SEL_DATO;
                  dato_out <= '0;
                  valido   <= 1'b0;
                  ocupado  <= 1'b0;
                  error_to <= 1'b1;
               end
            end
            FIN, ERR: begin
               estado <= IDLE;
            end
            default: begin
               estado <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conexion_p1_a_p2.sv
// Scoreboard bench for conexion_p1_a_p2: expected fields queued at listo, compared while valido.
module tb_conexion_p1_a_p2;
   import conexion_p1_a_p2_pkg::*;

   localparam int unsigned W  = 5;
   localparam int unsigned TO = 8;

   typedef struct packed {
      logic [1:0]   sel;
      logic [W-1:0] dato;
   } exp_t;

   logic         clk, reset, listo, q_in, q1_in, ack;
   logic [W-1:0] qq_in, dato_out;
   logic [1:0]   sel;
   logic         valido, ocupado, hecho, error_to, perdido;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_hecho = 0;
   int   n_err   = 0;
   int   h0, e0, nv;

   conexion_p1_a_p2 #(.ANCHO_DATO(W), .TIMEOUT(TO), .ANCHO_CNT(8)) dut (
      .clk(clk), .reset(reset), .listo(listo), .qq_in(qq_in), .q_in(q_in),
      .q1_in(q1_in), .ack(ack), .dato_out(dato_out), .sel(sel), .valido(valido),
      .ocupado(ocupado), .hecho(hecho), .error_to(error_to), .perdido(perdido)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [W-1:0] qq, input logic q, input logic q1);
      qq_in = qq; q_in = q; q1_in = q1; listo = 1'b1;
      exp_q.push_back('{SEL_DATO, qq});
      exp_q.push_back('{SEL_Q, W'(q)});
      exp_q.push_back('{SEL_Q1, W'(q1)});
      tick();
      listo = 1'b0;
      qq_in = ~qq; q_in = ~q; q1_in = ~q1;
   endtask

   // Scoreboard: presented field must match queue head every valid cycle; ack retires it
   always @(negedge clk) begin
      if (!reset) begin
         if (hecho) n_hecho++;
         if (error_to) n_err++;
         if (valido) begin
            if (exp_q.size() == 0) begin
               chk("sb_vacio", 32'd1, 32'd0);
            end else begin
               chk("sb_sel", 32'(sel), 32'(exp_q[0].sel));
               chk("sb_dato", 32'(dato_out), 32'(exp_q[0].dato));
               if (ack) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      reset = 1'b1; listo = 1'b0; ack = 1'b0; qq_in = '0; q_in = 1'b0; q1_in = 1'b0;
      #12;
      chk("rst_valido", 32'(valido), 0);
      chk("rst_ocupado", 32'(ocupado), 0);
      chk("rst_dato", 32'(dato_out), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_flags", {29'd0, hecho, error_to, perdido}, 0);
      tick();
      reset = 1'b0;
      tick();

      // Nominal: ack tied high, one field per cycle
      ack = 1'b1;
      start(5'b10110, 1'b1, 1'b0);
      chk("nom_latencia", 32'(valido), 1);
      chk("nom_ocupado", 32'(ocupado), 1);
      repeat (3) tick();
      chk("nom_hecho", 32'(hecho), 1);
      chk("nom_ocupado_fin", 32'(ocupado), 0);
      chk("nom_valido_fin", 32'(valido), 0);
      tick();
      chk("nom_hecho_pulso", 32'(hecho), 0);
      chk("nom_cola", 32'(exp_q.size()), 0);

      // Slow consumer: ack every 4th cycle
      ack = 1'b0;
      e0 = n_err;
      start(5'b01001, 1'b0, 1'b1);
      for (int f = 0; f < 3; f++) begin
         repeat (3) tick();
         ack = 1'b1;
         tick();
         ack = 1'b0;
      end
      chk("lento_hecho", 32'(hecho), 1);
      chk("lento_sin_err", 32'(n_err), 32'(e0));
      tick();

      // Timeout: no ack, valido must last exactly TIMEOUT cycles
      start(5'b10101, 1'b0, 1'b0);
      nv = 0;
      while (valido && nv < 20) begin
         nv++;
         tick();
      end
      chk("to_ciclos", 32'(nv), 32'(TO));
      chk("to_error", 32'(error_to), 1);
      chk("to_hecho", 32'(hecho), 0);
      exp_q.delete();
      tick();
      chk("to_error_pulso", 32'(error_to), 0);
      chk("to_ocupado", 32'(ocupado), 0);

      // Overrun: listo in ENV_Q must not disturb the snapshot
      start(5'b10110, 1'b0, 1'b1);
      ack = 1'b1; tick(); ack = 1'b0;
      qq_in = 5'b00011; q_in = 1'b1; q1_in = 1'b0; listo = 1'b1;
      tick();
      listo = 1'b0;
      chk("ovr_perdido", 32'(perdido), 1);
      chk("ovr_sel", 32'(sel), 32'(SEL_Q));
      ack = 1'b1;
      repeat (2) tick();
      chk("ovr_hecho", 32'(hecho), 1);
      listo = 1'b1;
      tick();
      listo = 1'b0;
      chk("ovr_fin_ignorado", 32'(ocupado), 0);
      chk("ovr_perdido_fin", 32'(perdido), 1);
      start(5'b00011, 1'b1, 1'b1);
      chk("ovr_perdido_limpio", 32'(perdido), 0);
      repeat (3) tick();
      chk("ovr_hecho2", 32'(hecho), 1);
      tick();

      // Async reset in ENV_Q1
      ack = 1'b0;
      start(5'b01101, 1'b1, 1'b0);
      ack = 1'b1; repeat (2) tick(); ack = 1'b0;
      chk("rm_sel_q1", 32'(sel), 32'(SEL_Q1));
      h0 = n_hecho; e0 = n_err;
      #2 reset = 1'b1;
      #1;
      chk("rm_async", {24'd0, dato_out, valido, ocupado, sel}, 0);
      chk("rm_flags", {29'd0, hecho, error_to, perdido}, 0);
      exp_q.delete();
      repeat (2) tick();
      reset = 1'b0;
      tick();
      chk("rm_sin_hecho", 32'(n_hecho), 32'(h0));
      chk("rm_sin_err", 32'(n_err), 32'(e0));
      ack = 1'b1;
      start(5'b11001, 1'b0, 1'b1);
      repeat (3) tick();
      chk("rm_hecho", 32'(hecho), 1);
      tick();

      // Ack on the expiry cycle wins over the watchdog
      ack = 1'b0;
      e0 = n_err;
      start(5'b00111, 1'b1, 1'b1);
      repeat (TO - 1) tick();
      ack = 1'b1;
      tick();
      chk("race_sin_err", 32'(error_to), 0);
      chk("race_valido", 32'(valido), 1);
      chk("race_sel", 32'(sel), 32'(SEL_Q));
      repeat (2) tick();
      chk("race_hecho", 32'(hecho), 1);
      ack = 1'b0;
      tick();
      chk("race_err_total", 32'(n_err), 32'(e0));
      chk("fin_cola", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
